// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shift controller: drives the shared one-bit-per-pass ALU shifter
// repeatedly, feeding each result back as the next operand until shamt passes are done.
module alu_shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   opnd,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  input  logic [WIDTH-1:0]   alu_otp,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [5:0]         alufn,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0]  OP_ILLEGAL = 2'b11;
  localparam logic [5:0]  ALUFN_PASS = 6'b000010;
  localparam logic [3:0]  ALUFN_SHIFT_HI = 4'b0010;

  state_t             state, state_next;
  logic [WIDTH-1:0]   acc, acc_next;
  logic [SHAMT_W-1:0] cnt, cnt_next;
  logic [1:0]         op_r, op_r_next;
  logic               err_next;
  logic               load_result;

  // load_result marks every transition into DONE so result/zero capture the
  // final accumulator value in the same edge that enters DONE.
  always_comb begin
    state_next  = state;
    acc_next    = acc;
    cnt_next    = cnt;
    op_r_next   = op_r;
    err_next    = err;
    load_result = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_next  = opnd;
          op_r_next = op;
          if (op == OP_ILLEGAL) begin
            err_next    = 1'b1;
            cnt_next    = '0;
            state_next  = DONE;
            load_result = 1'b1;
          end else begin
            err_next = 1'b0;
            cnt_next = shamt;
            if (shamt == '0) begin
              state_next  = DONE;
              load_result = 1'b1;
            end else begin
              state_next = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          acc_next = alu_otp;
          cnt_next = cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state_next  = DONE;
            load_result = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      op_r   <= '0;
      err    <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      op_r  <= op_r_next;
      err   <= err_next;
      if (load_result) begin
        result <= acc_next;
        zero   <= (acc_next == '0);
      end
    end
  end

  // A flush landing in DONE suppresses the pulse so the aborted op never reports.
  always_comb begin
    alu_a = acc;
    alu_b = WIDTH'(1);
    alufn = (state == SHIFT) ? {ALUFN_SHIFT_HI, op_r} : ALUFN_PASS;
    busy  = (state != IDLE);
    done  = (state == DONE) && !flush;
  end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Self-checking bench for alu_shift_sequencer: behavioural ALU in the loop,
// expected results queued at start and compared when done pulses.
module tb_alu_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opnd;
  logic [4:0]  shamt;
  logic        flush;
  logic [31:0] alu_otp;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alufn;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        err;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        e;
    int          cyc;
    int          passes;
    int          base;
  } exp_t;

  exp_t expQ[$];
  exp_t got;
  int   cycle = 0;
  int   passCnt = 0;
  int   checkCount = 0;
  int   passCount = 0;

  alu_shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opnd(opnd), .shamt(shamt),
    .flush(flush), .alu_otp(alu_otp), .alu_a(alu_a), .alu_b(alu_b), .alufn(alufn),
    .busy(busy), .done(done), .result(result), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural one-bit shifter standing in for the shared ALU
  always_comb begin
    case (alufn)
      6'b001000: alu_otp = alu_a << 1;
      6'b001001: alu_otp = $signed(alu_a) >>> 1;
      6'b001010: alu_otp = alu_a >> 1;
      default:   alu_otp = alu_a;
    endcase
  end

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (alufn[5:2] == 4'b0010) passCnt <= passCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  function automatic logic [31:0] modelShift(input logic [1:0] o, input logic [31:0] v, input int n);
    logic [31:0] r;
    r = v;
    for (int k = 0; k < n; k++) begin
      case (o)
        2'b00:   r = r << 1;
        2'b01:   r = $signed(r) >>> 1;
        default: r = r >> 1;
      endcase
    end
    return r;
  endfunction

  // Scoreboard side: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        got = expQ.pop_front();
        checkOutput("result", result, got.res);
        checkOutput("zero", {31'b0, zero}, {31'b0, got.z});
        checkOutput("err", {31'b0, err}, {31'b0, got.e});
        checkOutput("done_cycle", cycle, got.cyc);
        checkOutput("alu_passes", passCnt - got.base, got.passes);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] opndIn, input logic [4:0] shamtIn);
    exp_t e;
    int   lat;
    lat = (opIn == 2'b11 || shamtIn == 5'd0) ? 1 : int'(shamtIn) + 1;
    @(negedge clk);
    start = 1'b1;
    op    = opIn;
    opnd  = opndIn;
    shamt = shamtIn;
    e.res    = (opIn == 2'b11) ? opndIn : modelShift(opIn, opndIn, int'(shamtIn));
    e.z      = (e.res == 32'd0);
    e.e      = (opIn == 2'b11);
    e.cyc    = cycle + lat;
    e.passes = (opIn == 2'b11) ? 0 : int'(shamtIn);
    e.base   = passCnt;
    expQ.push_back(e);
    for (int i = 1; i <= lat + 1; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        op    = 2'b10;
        opnd  = 32'hDEAD_BEEF;
        shamt = 5'd3;
      end
      checkOutput("busy", {31'b0, busy}, (i <= lat) ? 32'd1 : 32'd0);
    end
    if (expQ.size() != 0) begin
      checkOutput("done_missing", expQ.size(), 32'd0);
      expQ.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; opnd = '0; shamt = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_flags", {30'b0, zero, err}, 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("alu_b", alu_b, 32'd1);
    checkOutput("idle_alufn", {26'b0, alufn}, 32'd2);
    rst = 1'b0;

    applyStimulus(2'b00, 32'h0000_0001, 5'd4);
    applyStimulus(2'b01, 32'h8000_0000, 5'd31);
    applyStimulus(2'b10, 32'h0000_00F0, 5'd0);
    applyStimulus(2'b11, 32'h0000_1234, 5'd5);
    applyStimulus(2'b00, 32'h0000_0001, 5'd1);

    // Flush mid-shift, with a second start while busy that must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'b00; opnd = 32'h0000_0005; shamt = 5'd8;
    @(negedge clk);
    op = 2'b10; opnd = 32'hFFFF_FFFF; shamt = 5'd0;
    checkOutput("flush_busy_c1", {31'b0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy_c3", {31'b0, busy}, 32'd0);
    checkOutput("flush_result_hold", result, 32'd2);
    repeat (10) @(negedge clk);
    checkOutput("flush_no_restart", {31'b0, busy}, 32'd0);
    checkOutput("flush_result_late", result, 32'd2);

    // Asynchronous reset in the middle of a shift
    @(negedge clk);
    start = 1'b1; op = 2'b00; opnd = 32'h0000_0001; shamt = 5'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", {31'b0, busy}, 32'd0);
    checkOutput("arst_result", result, 32'd0);
    checkOutput("arst_alu_a", alu_a, 32'd0);
    checkOutput("arst_flags", {29'b0, done, zero, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(2'b10, 32'h0000_0080, 5'd7);
    applyStimulus(2'b10, 32'h0000_0001, 5'd3);
    applyStimulus(2'b01, 32'h7FFF_0000, 5'd5);
    applyStimulus(2'b01, 32'hF000_000F, 5'd2);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
